// File: rtl/sigmoid_layer_pkg.sv
// sigmoid_layer_pkg
// Shared types and timing constants for the sigmoid layer sequencer.
//   state_t          : sequencer FSM states
//   MEM_RD_LAT       : weight/input/bias memory read latency (cycles)
//   ALU_PIPE_LAT     : cycles from read address issue until the ALU needs
//                      accumulate (memory read + ALU adder register)
//   VALID_PIPE_DEPTH : depth of the address-valid shift register
//   DRAIN_CYCLES     : cycles spent letting the pipe empty after the last group
package sigmoid_layer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN,
        WRITE,
        DONE
    } state_t;

    localparam int MEM_RD_LAT       = 1;
    localparam int ALU_PIPE_LAT     = 2;
    localparam int VALID_PIPE_DEPTH = ALU_PIPE_LAT;
    localparam int DRAIN_CYCLES     = ALU_PIPE_LAT;

endpackage

// File: rtl/sigmoid_layer_valid_pipe.sv
// sigmoid_layer_valid_pipe
// 1-bit shift register that delays "address valid" until the matching
// operands have reached the ALU adder register.
//   clk  : system clock
//   rst  : synchronous active-high reset, empties the pipe
//   din  : address valid for the current cycle
//   dout : delayed valid, used as the ALU accumulate enable
module sigmoid_layer_valid_pipe
    import sigmoid_layer_pkg::*;
#(
    parameter int DEPTH = VALID_PIPE_DEPTH
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] vld_p;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    assign dout = vld_p[DEPTH-1];

endmodule

// File: rtl/sigmoid_layer_sequencer.sv
// sigmoid_layer_sequencer
// Sequences one fully-connected layer through the sigmoid ALU, one neuron at
// a time: clear, stream NUM_GROUPS weight/input groups, drain the ALU pipe,
// write the activation to the result memory.
//   clk, rst       : clock, synchronous active-high reset
//   start          : begin a layer (only honoured in IDLE)
//   weight_addr    : weight group address = neuron*NUM_GROUPS + group
//   input_addr     : input group address = group
//   bias_addr      : bias address = current neuron
//   alu_clear      : clears the ALU accumulator
//   alu_accumulate : ALU accumulate enable, aligned with the adder register
//   alu_out        : ALU sigmoid output
//   res_we/res_addr/res_data : result memory write port
//   busy           : layer in progress (CLEAR of neuron 0 through DONE)
//   done           : one-cycle pulse at the end of the layer
module sigmoid_layer_sequencer
    import sigmoid_layer_pkg::*;
#(
    parameter int NUM_GROUPS  = 196,
    parameter int NUM_NEURONS = 16,
    parameter int GRP_W       = $clog2(NUM_GROUPS),
    parameter int NEU_W       = $clog2(NUM_NEURONS),
    parameter int WADDR_W     = $clog2(NUM_GROUPS*NUM_NEURONS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [WADDR_W-1:0] weight_addr,
    output logic [GRP_W-1:0]   input_addr,
    output logic [NEU_W-1:0]   bias_addr,
    output logic               alu_clear,
    output logic               alu_accumulate,
    input  logic [4:0]         alu_out,
    output logic               res_we,
    output logic [NEU_W-1:0]   res_addr,
    output logic [4:0]         res_data,
    output logic               busy,
    output logic               done
);

    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    state_t             state;
    state_t             state_next;
    logic [GRP_W-1:0]   group;
    logic [NEU_W-1:0]   neuron;
    logic [WADDR_W-1:0] waddr;
    logic [DRAIN_W-1:0] drain_cnt;
    logic               addr_valid;

    logic last_group;
    logic last_neuron;
    logic last_drain;

    assign last_group  = (group == GRP_W'(NUM_GROUPS - 1));
    assign last_neuron = (neuron == NEU_W'(NUM_NEURONS - 1));
    assign last_drain  = (drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1));

    // State register and counters. The weight address runs as its own
    // counter across neurons so neuron*NUM_GROUPS + group needs no multiplier;
    // it reaches neuron*NUM_GROUPS exactly at each CLEAR.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            group     <= '0;
            neuron    <= '0;
            waddr     <= '0;
            drain_cnt <= '0;
        end else begin
            state <= state_next;
            case (state)
                CLEAR: begin
                    group     <= '0;
                    drain_cnt <= '0;
                end
                STREAM: begin
                    group <= last_group ? '0 : group + 1'b1;
                    waddr <= waddr + 1'b1;
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt + 1'b1;
                end
                WRITE: begin
                    // Returning neuron/waddr to 0 at layer end keeps DONE and
                    // IDLE addresses at zero and readies the next layer.
                    if (last_neuron) begin
                        neuron <= '0;
                        waddr  <= '0;
                    end else begin
                        neuron <= neuron + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next state and Moore outputs
    always_comb begin
        state_next  = state;
        weight_addr = '0;
        input_addr  = '0;
        bias_addr   = '0;
        alu_clear   = 1'b0;
        res_we      = 1'b0;
        res_addr    = '0;
        res_data    = '0;
        busy        = 1'b0;
        done        = 1'b0;
        addr_valid  = 1'b0;

        case (state)
            IDLE: begin
                if (start) state_next = CLEAR;
            end
            CLEAR: begin
                busy       = 1'b1;
                alu_clear  = 1'b1;
                bias_addr  = neuron;
                state_next = STREAM;
            end
            STREAM: begin
                busy        = 1'b1;
                bias_addr   = neuron;
                weight_addr = waddr;
                input_addr  = group;
                addr_valid  = 1'b1;
                if (last_group) state_next = DRAIN;
            end
            DRAIN: begin
                busy      = 1'b1;
                bias_addr = neuron;
                if (last_drain) state_next = WRITE;
            end
            WRITE: begin
                busy       = 1'b1;
                bias_addr  = neuron;
                res_we     = 1'b1;
                res_addr   = neuron;
                res_data   = alu_out;
                state_next = last_neuron ? DONE : CLEAR;
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Accumulate is the address-valid flag delayed by the memory read and the
    // ALU adder register; nothing else drives it.
    sigmoid_layer_valid_pipe #(
        .DEPTH (VALID_PIPE_DEPTH)
    ) u_valid_pipe (
        .clk  (clk),
        .rst  (rst),
        .din  (addr_valid),
        .dout (alu_accumulate)
    );

    // The pipe is always empty by CLEAR because DRAIN waits out its full depth.
    clear_accumulate_exclusive: assert property (
        @(posedge clk) disable iff (rst) !(alu_clear && alu_accumulate)
    );

endmodule

// File: tb/tb_sigmoid_layer_sequencer.sv
module tb_sigmoid_layer_sequencer;

    localparam int NG      = 3;
    localparam int NN      = 2;
    localparam int GRP_W   = $clog2(NG);
    localparam int NEU_W   = $clog2(NN);
    localparam int WADDR_W = $clog2(NG*NN);

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [WADDR_W-1:0] weight_addr;
    logic [GRP_W-1:0]   input_addr;
    logic [NEU_W-1:0]   bias_addr;
    logic               alu_clear;
    logic               alu_accumulate;
    logic [4:0]         alu_out;
    logic               res_we;
    logic [NEU_W-1:0]   res_addr;
    logic [4:0]         res_data;
    logic               busy;
    logic               done;

    always #5 clk = ~clk;

    sigmoid_layer_sequencer #(
        .NUM_GROUPS  (NG),
        .NUM_NEURONS (NN)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .weight_addr    (weight_addr),
        .input_addr     (input_addr),
        .bias_addr      (bias_addr),
        .alu_clear      (alu_clear),
        .alu_accumulate (alu_accumulate),
        .alu_out        (alu_out),
        .res_we         (res_we),
        .res_addr       (res_addr),
        .res_data       (res_data),
        .busy           (busy),
        .done           (done)
    );

    // Memories with 1-cycle read latency and a small ALU model:
    // signed 4-bit weights times unsigned 4-bit inputs, 4 lanes per group,
    // adder register, then accumulate; activation stand-in is
    // clamp((accum + bias) >>> 2, 0, 31).
    logic [15:0]       wmem [NG*NN];
    logic [15:0]       xmem [NG];
    logic signed [7:0] bmem [NN];
    logic [15:0]       wq;
    logic [15:0]       xq;
    logic signed [7:0] bq;
    int                added;
    int                accum;

    always @(posedge clk) begin
        int s;
        s = 0;
        for (int l = 0; l < 4; l++) s += $signed(wq[4*l +: 4]) * int'(xq[4*l +: 4]);
        wq    <= wmem[weight_addr];
        xq    <= xmem[input_addr];
        bq    <= bmem[bias_addr];
        added <= s;
        if (alu_clear) accum <= 0;
        else if (alu_accumulate) accum <= accum + added;
    end

    always_comb begin
        int v;
        v = (accum + int'(bq)) >>> 2;
        alu_out = '0;
        if (v < 0) alu_out = '0;
        else if (v > 31) alu_out = 5'd31;
        else alu_out = v[4:0];
    end

    // Hand-derived per-cycle trace of one layer (NG=3, NN=2), start in cycle 0.
    int t_clr [17] = '{0,1,0,0,0,0,0,0,1,0,0,0,0,0,0,0,0};
    int t_acc [17] = '{0,0,0,0,1,1,1,0,0,0,0,1,1,1,0,0,0};
    int t_we  [17] = '{0,0,0,0,0,0,0,1,0,0,0,0,0,0,1,0,0};
    int t_dn  [17] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1,0};
    int t_bsy [17] = '{0,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,0};
    int t_wa  [17] = '{0,0,0,1,2,0,0,0,0,3,4,5,0,0,0,0,0};
    int t_ia  [17] = '{0,0,0,1,2,0,0,0,0,0,1,2,0,0,0,0,0};
    int t_ba  [17] = '{0,0,0,0,0,0,0,0,1,1,1,1,1,1,1,0,0};
    int t_ra  [17] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,1,0,0};

    typedef struct {
        int cyc;
        int clr, acc, we, dn, bsy, wa, ia, ba, ra, rd;
    } tr_t;

    typedef struct {
        int cyc;
        int addr;
        int data;
    } wr_t;

    tr_t trq [$];
    wr_t wrq [$];
    int  dnq [$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push_idle(input int at, input int n);
        for (int i = 0; i < n; i++) trq.push_back('{at + i, 0,0,0,0,0,0,0,0,0,0});
    endtask

    task automatic push_layer(input int base, input int first, input int data);
        for (int n = first; n < 17; n++)
            trq.push_back('{base + n, t_clr[n], t_acc[n], t_we[n], t_dn[n], t_bsy[n],
                            t_wa[n], t_ia[n], t_ba[n], t_ra[n], (t_we[n] != 0) ? data : 0});
        wrq.push_back('{base + 7, 0, data});
        wrq.push_back('{base + 14, 1, data});
        dnq.push_back(base + 15);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic run_layer(input int data, input bit extra);
        int base;
        next_cycle();
        base = cyc;
        push_layer(base, 0, data);
        push_idle(base + 17, 3);
        start = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            next_cycle();
            start = extra && (n == 3 || n == 10);
        end
        start = 1'b0;
    endtask

    // Monitor: compares whatever the DUT presents against queued expectations.
    always @(negedge clk) begin
        tr_t e;
        wr_t w;
        int  d;
        while (trq.size() > 0 && trq[0].cyc < cyc) begin
            e = trq.pop_front();
            checks++;
            errors++;
            $display("FAIL trace_missed cyc %0d: expectation never compared", e.cyc);
        end
        if (trq.size() > 0 && trq[0].cyc == cyc) begin
            e = trq.pop_front();
            checks++;
            if (int'(alu_clear) != e.clr || int'(alu_accumulate) != e.acc || int'(res_we) != e.we ||
                int'(done) != e.dn || int'(busy) != e.bsy || int'(weight_addr) != e.wa ||
                int'(input_addr) != e.ia || int'(bias_addr) != e.ba || int'(res_addr) != e.ra ||
                int'(res_data) != e.rd) begin
                errors++;
                $display("FAIL trace cyc %0d: got clr=%0d acc=%0d we=%0d done=%0d busy=%0d wa=%0d ia=%0d ba=%0d ra=%0d rd=%0d, required clr=%0d acc=%0d we=%0d done=%0d busy=%0d wa=%0d ia=%0d ba=%0d ra=%0d rd=%0d",
                         cyc, alu_clear, alu_accumulate, res_we, done, busy, weight_addr, input_addr,
                         bias_addr, res_addr, res_data, e.clr, e.acc, e.we, e.dn, e.bsy, e.wa, e.ia,
                         e.ba, e.ra, e.rd);
            end
        end
        if (res_we) begin
            checks++;
            if (wrq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write cyc %0d: got addr=%0d data=%0d, required no write",
                         cyc, res_addr, res_data);
            end else begin
                w = wrq.pop_front();
                if (w.cyc != cyc || w.addr != int'(res_addr) || w.data != int'(res_data)) begin
                    errors++;
                    $display("FAIL result_write: got cyc=%0d addr=%0d data=%0d, required cyc=%0d addr=%0d data=%0d",
                             cyc, res_addr, res_data, w.cyc, w.addr, w.data);
                end
            end
        end
        if (done) begin
            checks++;
            if (dnq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done cyc %0d: got done=1, required 0", cyc);
            end else begin
                d = dnq.pop_front();
                if (d != cyc) begin
                    errors++;
                    $display("FAIL done_cycle: got %0d, required %0d", cyc, d);
                end
            end
        end
        if (!rst) begin
            checks++;
            if (alu_clear && alu_accumulate) begin
                errors++;
                $display("FAIL clear_acc_exclusive cyc %0d: got both high, required at most one", cyc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst   = 1'b1;
        start = 1'b0;
        for (int i = 0; i < NG*NN; i++) wmem[i] = 16'h1111;
        for (int i = 0; i < NG; i++) xmem[i] = 16'h8888;
        for (int i = 0; i < NN; i++) bmem[i] = 8'sd0;

        // Reset state
        repeat (3) next_cycle();
        push_idle(cyc + 1, 3);
        next_cycle();
        rst = 1'b0;
        repeat (3) next_cycle();

        // Timing and data path: each group 4*(1*8)=32, 3 groups = 96, 96>>2 = 24
        run_layer(24, 1'b0);

        // Extra start pulses in cycles 3 and 10 are ignored
        run_layer(24, 1'b1);

        // Negative weights: -96 -> clamps to 0
        for (int i = 0; i < NG*NN; i++) wmem[i] = 16'hFFFF;
        run_layer(0, 1'b0);
        for (int i = 0; i < NG*NN; i++) wmem[i] = 16'h1111;

        // Reset for 3 cycles mid-STREAM: idle from the next cycle, no write, no done
        next_cycle();
        base  = cyc;
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        next_cycle();
        next_cycle();
        push_idle(base + 4, 14);
        rst = 1'b1;
        next_cycle();
        next_cycle();
        next_cycle();
        rst = 1'b0;
        repeat (14) next_cycle();

        // Back-to-back layers with start held high: second CLEAR in cycle 17
        next_cycle();
        base = cyc;
        push_layer(base, 0, 24);
        push_layer(base + 16, 1, 24);
        push_idle(base + 33, 3);
        start = 1'b1;
        repeat (18) next_cycle();
        start = 1'b0;
        repeat (20) next_cycle();

        // Every queued expectation must have been consumed
        checks++;
        if (trq.size() != 0) begin
            errors++;
            $display("FAIL trace_leftover: got %0d pending, required 0", trq.size());
        end
        checks++;
        if (wrq.size() != 0) begin
            errors++;
            $display("FAIL write_leftover: got %0d pending, required 0", wrq.size());
        end
        checks++;
        if (dnq.size() != 0) begin
            errors++;
            $display("FAIL done_leftover: got %0d pending, required 0", dnq.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
